// File: rtl/sistema_pulse_pio.sv
// sistema_pulse_pio: Avalon-MM output PIO with a static pattern register and
// hardware-timed pulses on a selectable group of output bits.
module sistema_pulse_pio #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_reg, data_nxt;
    logic [WIDTH-1:0] mask, mask_nxt;
    logic [WIDTH-1:0] pulse_mask, pulse_mask_nxt;
    logic [CNT_W-1:0] pulse_len, pulse_len_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             irq_en, irq_en_nxt;
    logic             done, done_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [31:0]      rd_nxt;
    logic             wr;
    logic             unused_bits;

    // CTRL read view: MASK in bits WIDTH+7:8, IRQ_EN in bit1, START reads 0.
    function automatic logic [31:0] ctrl_word(input logic [WIDTH-1:0] m,
                                              input logic             ie);
        logic [31:0] w;
        w    = 32'(m) << 8;
        w[1] = ie;
        return w;
    endfunction

    // STATUS read view: remaining count from bit8 up (truncated to 32 bits),
    // DONE in bit1, BUSY in bit0.
    function automatic logic [31:0] status_word(input logic [CNT_W-1:0] c,
                                                input logic             d,
                                                input logic             b);
        logic [63:0] w;
        w    = 64'(c) << 8;
        w[1] = d;
        w[0] = b;
        return w[31:0];
    endfunction

    assign wr          = chipselect && !write_n;
    assign irq         = done & irq_en;
    assign unused_bits = &{1'b0, writedata};

    // Next-state, register-write and output decode; DONE set overrides W1C.
    always_comb begin
        state_nxt      = state;
        data_nxt       = data_reg;
        mask_nxt       = mask;
        pulse_mask_nxt = pulse_mask;
        pulse_len_nxt  = pulse_len;
        cnt_nxt        = cnt;
        irq_en_nxt     = irq_en;
        done_nxt       = done;

        if (wr) begin
            case (address)
                2'd0: data_nxt = writedata[WIDTH-1:0];
                2'd1: pulse_len_nxt = writedata[CNT_W-1:0];
                2'd2: begin
                    mask_nxt   = writedata[WIDTH+7:8];
                    irq_en_nxt = writedata[1];
                end
                default: begin
                    if (writedata[1]) begin
                        done_nxt = 1'b0;
                    end
                end
            endcase
        end

        case (state)
            IDLE: begin
                if (wr && address == 2'd2 && writedata[0] && pulse_len != '0) begin
                    state_nxt      = ACTIVE;
                    pulse_mask_nxt = writedata[WIDTH+7:8];
                    cnt_nxt        = pulse_len;
                end
            end
            default: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
        endcase

        // Output pins reflect the post-edge state so the pulse starts on the
        // same edge that accepts START.
        out_nxt = data_nxt | ((state_nxt == ACTIVE) ? pulse_mask_nxt : '0);

        case (address)
            2'd0:    rd_nxt = 32'(out_port);
            2'd1:    rd_nxt = 32'(pulse_len);
            2'd2:    rd_nxt = ctrl_word(mask, irq_en);
            default: rd_nxt = status_word(cnt, done, state == ACTIVE);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register file, pulse counter, output pins and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= '0;
            mask       <= '0;
            pulse_mask <= '0;
            pulse_len  <= '0;
            cnt        <= '0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            out_port   <= '0;
            readdata   <= '0;
        end else begin
            data_reg   <= data_nxt;
            mask       <= mask_nxt;
            pulse_mask <= pulse_mask_nxt;
            pulse_len  <= pulse_len_nxt;
            cnt        <= cnt_nxt;
            irq_en     <= irq_en_nxt;
            done       <= done_nxt;
            out_port   <= out_nxt;
            readdata   <= rd_nxt;
        end
    end

endmodule
